// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detector: load-use / branch-operand stalls of 1 or 2 cycles, IF/ID flush on taken branch or jump.
// Stall/flush outputs are combinational from inputs and state; a saturating counter tracks total stall cycles.
module hazard_detect_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_branch_i,
    input  logic                  id_jump_i,
    input  logic                  branch_taken_i,
    input  logic                  idex_memread_i,
    input  logic                  idex_regwrite_i,
    input  logic [REG_ADDR_W-1:0] idex_wreg_i,
    input  logic                  exmem_memread_i,
    input  logic [REG_ADDR_W-1:0] exmem_wreg_i,
    output logic                  hazard_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    typedef enum logic {RUN, STALL} state_t;

    state_t           state_q, state_d;
    logic             rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       ex_match, mem_match;
    logic [1:0] need;
    logic       stall;

    // Register 0 is hardwired, so it can never create a dependency.
    assign ex_match  = (idex_wreg_i != '0) &&
                       ((idex_wreg_i == ifid_rs_i) || (id_uses_rt_i && (idex_wreg_i == ifid_rt_i)));
    assign mem_match = (exmem_wreg_i != '0) &&
                       ((exmem_wreg_i == ifid_rs_i) || (id_uses_rt_i && (exmem_wreg_i == ifid_rt_i)));

    always_comb begin
        need = 2'd0;
        if (id_branch_i && idex_memread_i && ex_match)
            need = 2'd2;
        else if (idex_memread_i && ex_match)
            need = 2'd1;
        else if (id_branch_i && idex_regwrite_i && ex_match)
            need = 2'd1;
        else if (id_branch_i && exmem_memread_i && mem_match)
            need = 2'd1;
    end

    assign stall = !reset_i && ((state_q == STALL) || (need != 2'd0));

    // Flush waits for a non-stall cycle: branch operands are not valid while stalled.
    always_comb begin
        hazard_o     = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        if (!reset_i) begin
            hazard_o     = stall;
            pc_write_o   = !stall;
            ifid_write_o = !stall;
            ifid_flush_o = !stall && (id_jump_i || (id_branch_i && branch_taken_i));
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (need == 2'd2) begin
                    state_d = STALL;
                    rem_d   = 1'b1;
                end
            end
            STALL: begin
                rem_d = rem_q - 1'b1;
                if (rem_d == 1'b0)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (hazard_o && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RUN;
            rem_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count_o = cnt_q;

endmodule
